// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver with a runtime-programmable bit period feeding a small
//   receive FIFO with a valid/ready read port and sticky error flags.
//
// Parameters
//   DEPTH       : receive FIFO entries (power of two, 2..64)
//   DEFAULT_DIV : bit period in clk cycles after reset
//
// Ports
//   clk        : sole clock, rising edge
//   resetn     : asynchronous active-low reset
//   ser_rx     : asynchronous serial line, idle high
//   cfg_div_we : write strobe for cfg_div
//   cfg_div    : new bit period in clk cycles (values below 4 clamp to 4)
//   err_clr    : clears overflow and frame_err
//   rd_valid   : FIFO non-empty, rd_data valid
//   rd_data    : oldest received byte
//   rd_ready   : consumer accepts rd_data when high together with rd_valid
//   count      : current FIFO occupancy
//   overflow   : sticky, a byte was dropped because the FIFO was full
//   frame_err  : sticky, a stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int DEFAULT_DIV = 106
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ser_rx,
    input  logic                     cfg_div_we,
    input  logic [15:0]              cfg_div,
    input  logic                     err_clr,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Synchronizer and edge detection
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;

    // Divider registers
    logic [15:0] r_div;
    logic [15:0] r_frame_div;

    // Receiver FSM state
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    // FIFO storage and pointers
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    // Combinational helpers
    logic          w_fall;
    logic          w_cnt_zero;
    logic          w_push;
    logic          w_frame_err_set;
    logic          w_pop;
    logic          w_full;
    logic          w_do_push;
    logic          w_overflow_set;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_remain;
    logic [AW-1:0] w_rptr_nxt;
    logic [7:0]    w_rd_data_nxt;

    // Two-flop synchronizer; flops reset to the idle (high) line level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= ser_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Programmable bit period, clamped so the half-bit count stays nonzero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div <= 16'(DEFAULT_DIV);
        end else if (cfg_div_we) begin
            r_div <= (cfg_div < 16'd4) ? 16'd4 : cfg_div;
        end else begin
            r_div <= r_div;
        end
    end

    // Receiver decode terms
    always_comb begin
        w_fall          = r_rx_prev & ~r_sync2;
        w_cnt_zero      = (r_cnt == 16'd0);
        w_push          = 1'b0;
        w_frame_err_set = 1'b0;
        if ((r_state == ST_STOP) && w_cnt_zero) begin
            w_push          = r_sync2;
            w_frame_err_set = ~r_sync2;
        end else begin
            w_push          = 1'b0;
            w_frame_err_set = 1'b0;
        end
    end

    // Receiver FSM: start qualification, LSB-first data shift, stop check
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_frame_div <= 16'(DEFAULT_DIV);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        // Frame divider is frozen here so mid-frame writes wait
                        r_frame_div <= r_div;
                        r_cnt       <= (r_div >> 1) - 16'd1;
                        r_state     <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (w_cnt_zero) begin
                        if (!r_sync2) begin
                            r_cnt     <= r_frame_div - 16'd1;
                            r_bit_idx <= 3'd0;
                            r_state   <= ST_DATA;
                        end else begin
                            // Line back high at mid-start: glitch, no flag
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_cnt_zero) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= r_frame_div - 16'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_cnt_zero) begin
                        r_state <= r_sync2 ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low break produces a single frame error
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO control: pop/push arbitration and next read head
    always_comb begin
        w_pop          = rd_valid & rd_ready;
        w_full         = (count == CW'(DEPTH));
        w_do_push      = w_push & (~w_full | w_pop);
        w_overflow_set = w_push & w_full & ~w_pop;
        w_count_nxt    = count + CW'(w_do_push) - CW'(w_pop);
        w_remain       = count - CW'(w_pop);
        w_rptr_nxt     = w_pop ? (r_rptr + AW'(1)) : r_rptr;
        w_rd_data_nxt  = rd_data;
        if (w_count_nxt == CW'(0)) begin
            w_rd_data_nxt = rd_data;
        end else if (w_do_push && (w_remain == CW'(0))) begin
            // The byte being written becomes the head immediately
            w_rd_data_nxt = r_shift;
        end else begin
            w_rd_data_nxt = r_mem[w_rptr_nxt];
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= r_shift;
        end else begin
            r_mem[r_wptr] <= r_mem[r_wptr];
        end
    end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            r_wptr   <= w_do_push ? (r_wptr + AW'(1)) : r_wptr;
            r_rptr   <= w_rptr_nxt;
            count    <= w_count_nxt;
            rd_valid <= (w_count_nxt != CW'(0));
            rd_data  <= w_rd_data_nxt;
        end
    end

    // Sticky error flags; a coincident set beats err_clr
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_overflow_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
            if (w_frame_err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end else begin
                frame_err <= frame_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (DEPTH=8, DEFAULT_DIV=106). Serial frames
//   are generated at a known bit period; expected bytes and flags are fixed
//   constants for each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic        clk;
    logic        resetn;
    logic        ser_rx;
    logic        cfg_div_we;
    logic [15:0] cfg_div;
    logic        err_clr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic [3:0]  count;
    logic        overflow;
    logic        frame_err;

    int n_checks;
    int n_fail;

    uart_rx_fifo #(
        .DEPTH       (8),
        .DEFAULT_DIV (106)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .cfg_div_we (cfg_div_we),
        .cfg_div    (cfg_div),
        .err_clr    (err_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .count      (count),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one 8N1 frame; stop_lvl=0 leaves the line low afterwards
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int bit_clks);
        ser_rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        ser_rx = stop_lvl;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_checks++;
        if ({overflow, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overflow, frame_err}); end
    endtask

    task automatic test_single_byte();
        send_byte(8'h41, 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rd_valid); end
        n_checks++;
        if (rd_data !== 8'h41) begin n_fail++; $display("FAIL single_data got %h want 41", rd_data); end
        n_checks++;
        if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_frame_err got %b want 0", frame_err); end
        pop_one();
        n_checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop got count=%0d valid=%b want 0/0", count, rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (count !== 4'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
                n_fail++; $display("FAIL b2b_pop%0d got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp_b[i]);
            end
            pop_one();
        end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(i + 1);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                n_fail++; $display("FAIL ovf_pop%0d got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp_b);
            end
            pop_one();
        end
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL ovf_drained got valid=%b count=%0d want 0/0", rd_valid, count); end
        pulse_err_clr();
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_frame_err();
        send_byte(8'h3C, 1'b0, 106);
        repeat (106) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", frame_err); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL ferr_no_push got count=%0d want 0", count); end
        // Clear while the break is still held; it must not be raised again
        pulse_err_clr();
        repeat (211) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_once got %b want 0", frame_err); end
        ser_rx = 1'b1;
        repeat (106) @(negedge clk);
        send_byte(8'h7E, 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h7E || count !== 4'd1) begin
            n_fail++; $display("FAIL ferr_recover got valid=%b data=%h count=%0d want 1/7e/1", rd_valid, rd_data, count);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_recover_flag got %b want 0", frame_err); end
        pop_one();
    endtask

    task automatic test_glitch();
        ser_rx = 1'b0;
        repeat (20) @(negedge clk);
        ser_rx = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_push got count=%0d valid=%b want 0/0", count, rd_valid); end
        n_checks++;
        if ({overflow, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got %b want 00", {overflow, frame_err}); end
        // Receiver must be idle and ready for a normal frame
        send_byte(8'hC3, 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_data !== 8'hC3 || count !== 4'd1) begin n_fail++; $display("FAIL glitch_next got data=%h count=%0d want c3/1", rd_data, count); end
        pop_one();
    endtask

    task automatic test_div_and_reset();
        cfg_div    = 16'd2;
        cfg_div_we = 1'b1;
        @(negedge clk);
        cfg_div_we = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hA5, 1'b1, 4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 4'd1) begin
            n_fail++; $display("FAIL div4_rx got valid=%b data=%h count=%0d want 1/a5/1", rd_valid, rd_data, count);
        end
        pop_one();
        // Start another frame at 4 clk/bit and reset during bit 3
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1; repeat (4) @(negedge clk);
        ser_rx = 1'b0; repeat (4) @(negedge clk);
        ser_rx = 1'b1; repeat (4) @(negedge clk);
        ser_rx = 1'b0; repeat (2) @(negedge clk);
        resetn = 1'b0;
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_push got count=%0d valid=%b want 0/0", count, rd_valid); end
        // Bit period is back to 106: a 106-clk frame decodes correctly
        send_byte(8'h96, 1'b1, 106);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h96 || count !== 4'd1) begin n_fail++; $display("FAIL midreset_div got data=%h count=%0d want 96/1", rd_data, count); end
        pop_one();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b1;
        ser_rx     = 1'b1;
        cfg_div_we = 1'b0;
        cfg_div    = 16'd0;
        err_clr    = 1'b0;
        rd_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_div_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
